fpu: RTL and testbench
======================

# fpu

Single-precision (IEEE-754 binary32) arithmetic unit performing add, subtract and multiply on two packed operands, with one registered result per clock. Datapath is combinational from operands to a single output register; no handshake, a new operation may be presented every cycle. Sits as the floating-point execution block beside the integer ALU and is driven directly by operand and opcode registers.

## Interface
Parameters: none.

Clock and reset (already decided): one clock; reset is synchronous and active-high.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a_operand  in  32  operand A, binary32: [31] sign, [30:23] exponent, [22:0] fraction.
- b_operand  in  32  operand B, same format.
- operation  in  2  type pa_fpu::e_fpu_op:
  - op_add=0
  - op_sub=1
  - op_mul=2
  - op_div=3
- ieee_packet_out  out  32  registered binary32 result.

## Operation
- Unpack each operand: exponent 0 means zero or subnormal, with implicit bit 0 and effective exponent −126; exponent 255 means inf (fraction 0) or NaN.
- op_add: A+B. op_sub: A+(−B), with B's sign inverted before the adder. Align by exponent difference, keeping guard/round/sticky bits. Add or subtract the magnitudes, normalize with a leading-zero count, round.
- op_mul: sign = sA^sB, exponent = eA+eB−127. Form the 24x24 significand product, normalize (including subnormal inputs and outputs), round.
- op_div: not implemented; result is always 32'h7fc00000.
- Rounding: round-to-nearest-even on every result.
- Overflow gives ±inf (8'hff, fraction 0).
- Results below 2^−126 are emitted as subnormals (exponent 0, denormalized fraction). Total underflow gives a signed zero.
- Exact cancellation (x + (−x)) gives +0.
- (−0)+(−0) gives −0; (−0)−(+0) gives −0.
- Zero product sign follows sA^sB, e.g. 00000001 * 80000000 gives 80000000.
- Special cases, applied before arithmetic:
  - any NaN input gives 7fc00000;
  - inf−inf (effective) gives 7fc00000;
  - inf*0 gives 7fc00000;
  - inf ± finite gives the inf with its effective sign;
  - inf*finite-nonzero and inf*inf give inf with sign sA^sB.
- NaN output is always canonical 7fc00000: positive sign, quiet bit only set, payload discarded.
- Exceptions are not flagged; there are no status outputs.

## Timing
- Latency 1 cycle: operands and operation present before rising edge N produce ieee_packet_out after edge N.
- Throughput: one operation per cycle. Inputs are sampled every edge; there is no valid/ready.
- Reset: rst high at an edge loads ieee_packet_out = 32'h00000000 and overrides the computed value. The first valid result appears at the first edge with rst low.
- Output holds between edges. Changing inputs mid-cycle affects only the next registered value.

## Configuration
- FPU_SUBNORMAL_EN defined: full subnormal support as described in Operation.
- FPU_SUBNORMAL_EN undefined: flush-to-zero mode.
  - Subnormal inputs are treated as zero with their sign kept.
  - Results below 2^−126 are flushed to a zero carrying the computed sign.
  - Example: 00000001*3f800000 gives 00000000.
  - Special-case and rounding rules are otherwise unchanged.

## Test plan
- Normal values:
  - mul 3fffffff*402df854 gives 40adf853;
  - add 3f800000+3f8ccccd gives 40066666;
  - sub 3f800000−3f8ccccd gives bdccccd0;
  - mul 41800000*42000000 gives 44000000;
  - add 3e800000+3f000000 gives 3f400000.
- Subnormal mul (FPU_SUBNORMAL_EN):
  - 3fffffff*007fffff gives 00fffffd;
  - 00000001*41000000 gives 00000008;
  - 007fffff*007fffff gives 00000000;
  - 00000001*80000001 gives 80000000.
- Subnormal add/sub (FPU_SUBNORMAL_EN):
  - 007fffff+00000001 gives 00800000;
  - 00800000−007fffff gives 00000001;
  - 00000001−00000001 gives 00000000.
- Specials:
  - mul 7f800000*00000000 gives 7fc00000;
  - add ff800000+7f800000 gives 7fc00000;
  - sub 41200000−ff800000 gives 7f800000;
  - mul ff800000*ff800000 gives 7f800000;
  - any op with 7fc00000 input gives 7fc00000;
  - op_div with any operands gives 7fc00000.
- Reset/latency:
  - hold rst=1 for 2 cycles with 3f800000+3f800000 applied: output stays 00000000.
  - Release rst: output becomes 40000000 one edge later.
  - Change to op_mul: output becomes 3f800000 on the next edge.
- Back-to-back: apply a new vector every cycle for the full list; each result must appear exactly one edge after its inputs.

Source files
------------

// File: rtl/fpu.sv
// fpu: binary32 add/sub/mul with one registered result per cycle; define FPU_SUBNORMAL_EN for subnormals, otherwise flush-to-zero
package pa_fpu;
  typedef enum logic [1:0] {op_add = 2'd0, op_sub = 2'd1, op_mul = 2'd2, op_div = 2'd3} e_fpu_op;
endpackage

module fpu (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     a_operand,
  input  logic [31:0]     b_operand,
  input  pa_fpu::e_fpu_op operation,
  output logic [31:0]     ieee_packet_out
);
`ifdef FPU_SUBNORMAL_EN
  localparam bit sub_en = 1'b1;
`else
  localparam bit sub_en = 1'b0;
`endif
  logic sa, sb, sbe, a_nan, b_nan, a_inf, b_inf, is_mul, swap, s1, s2, rs, lost_a, lost_n, rnd_up, nan;
  logic [7:0] ea, eb;
  logic [23:0] ma, mb, m1, m2;
  logic signed [10:0] xa, xb, e1, d, e_in, e_lz, tgt, amt, rsh;
  logic [26:0] m2w, m2a;
  logic [27:0] sum;
  logic [47:0] prod, n, ns;
  logic [5:0] lz;
  logic [10:0] fld, res_e;
  logic [33:0] rnd;
  logic [31:0] arith, result;
  assign sa = a_operand[31];
  assign sb = b_operand[31];
  assign ea = a_operand[30:23];
  assign eb = b_operand[30:23];
  assign ma = (sub_en || |ea) ? {|ea, a_operand[22:0]} : 24'd0;
  assign mb = (sub_en || |eb) ? {|eb, b_operand[22:0]} : 24'd0;
  assign xa = |ea ? {3'b0, ea} : 11'sd1;
  assign xb = |eb ? {3'b0, eb} : 11'sd1;
  assign a_inf = &ea & ~|a_operand[22:0];
  assign b_inf = &eb & ~|b_operand[22:0];
  assign a_nan = &ea & |a_operand[22:0];
  assign b_nan = &eb & |b_operand[22:0];
  assign is_mul = operation == pa_fpu::op_mul;
  assign sbe = sb ^ (operation == pa_fpu::op_sub);
  assign swap = {xb, mb} > {xa, ma};
  assign s1 = swap ? sbe : sa;
  assign s2 = swap ? sa : sbe;
  assign e1 = swap ? xb : xa;
  assign m1 = swap ? mb : ma;
  assign m2 = swap ? ma : mb;
  assign d = swap ? xb - xa : xa - xb;
  assign m2w = {m2, 3'b0};
  assign lost_a = d > 11'sd26 ? |m2w : |(m2w & ~({27{1'b1}} << d));
  assign m2a = (d > 11'sd26 ? 27'd0 : m2w >> d) | {26'd0, lost_a};
  assign sum = s1 == s2 ? {1'b0, m1, 3'b0} + {1'b0, m2a} : {1'b0, m1, 3'b0} - {1'b0, m2a};
  assign prod = 48'(ma) * 48'(mb);
  // n is scaled so a leading one in bit 47 carries biased exponent e_in
  assign n = is_mul ? prod : {sum, 20'd0};
  assign e_in = is_mul ? xa + xb - 11'sd126 : e1 + 11'sd1;
  assign rs = is_mul ? sa ^ sb : (sum == 28'd0 ? s1 & s2 : s1);
  always_comb begin
    lz = 6'd48;
    for (int i = 0; i < 48; i++)
      if (n[i]) lz = 6'(47 - i);
  end
  // exponent floors at 1 so values below 2^-126 come out denormalized with bit 47 clear
  assign e_lz = e_in - $signed({5'd0, lz});
  assign tgt = e_lz > 11'sd0 ? e_lz : 11'sd1;
  assign amt = e_in - tgt;
  assign rsh = -amt;
  assign ns = amt >= 11'sd0 ? n << amt : (rsh >= 11'sd48 ? 48'd0 : n >> rsh);
  assign lost_n = amt >= 11'sd0 ? 1'b0 : (rsh >= 11'sd48 ? |n : |(n & ~({48{1'b1}} << rsh)));
  assign rnd_up = ns[23] & (|ns[22:0] | lost_n | ns[24]);
  assign fld = ns[47] ? tgt : 11'd0;
  assign rnd = {fld, ns[46:24]} + 34'(rnd_up);
  assign res_e = rnd[33:23];
  assign arith = res_e >= 11'd255 ? {rs, 8'hff, 23'd0} : (!sub_en && res_e == 11'd0) ? {rs, 31'd0} : {rs, rnd[30:0]};
  assign nan = a_nan | b_nan | operation == pa_fpu::op_div |
               (is_mul ? (a_inf & ~|mb) | (b_inf & ~|ma) : a_inf & b_inf & (sa ^ sbe));
  assign result = nan ? 32'h7fc00000 : (a_inf | b_inf) ? {is_mul ? sa ^ sb : (a_inf ? sa : sbe), 8'hff, 23'd0} : arith;
  always_ff @(posedge clk) ieee_packet_out <= rst ? 32'h0 : result;
endmodule

// File: tb/tb_fpu.sv
// tb_fpu: directed scoreboard bench for fpu in either subnormal or flush-to-zero build
module tb_fpu;
  import pa_fpu::*;
`ifdef FPU_SUBNORMAL_EN
  localparam bit sub_en = 1'b1;
`else
  localparam bit sub_en = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] a_operand = 32'h0;
  logic [31:0] b_operand = 32'h0;
  e_fpu_op operation = op_add;
  logic [31:0] ieee_packet_out;
  logic [31:0] exp_q[$];
  string tag_q[$];
  int checks = 0;
  int passed = 0;
  fpu dut (
    .clk(clk),
    .rst(rst),
    .a_operand(a_operand),
    .b_operand(b_operand),
    .operation(operation),
    .ieee_packet_out(ieee_packet_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b, input e_fpu_op op, input logic [31:0] e);
    a_operand = a;
    b_operand = b;
    operation = op;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check("scoreboard_empty", 32'h1, 32'h0);
    else check(tag_q.pop_front(), ieee_packet_out, exp_q.pop_front());
  endtask
  initial begin
    a_operand = 32'h3f800000;
    b_operand = 32'h3f800000;
    operation = op_add;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_hold", ieee_packet_out, 32'h0);
    end
    rst = 1'b0;
    step("reset_release", 32'h3f800000, 32'h3f800000, op_add, 32'h40000000);
    step("after_reset_mul", 32'h3f800000, 32'h3f800000, op_mul, 32'h3f800000);
    step("mul_norm", 32'h3fffffff, 32'h402df854, op_mul, 32'h40adf853);
    step("add_norm", 32'h3f800000, 32'h3f8ccccd, op_add, 32'h40066666);
    step("sub_norm", 32'h3f800000, 32'h3f8ccccd, op_sub, 32'hbdccccd0);
    step("mul_pow2", 32'h41800000, 32'h42000000, op_mul, 32'h44000000);
    step("add_frac", 32'h3e800000, 32'h3f000000, op_add, 32'h3f400000);
    step("mul_sub_a", 32'h3fffffff, 32'h007fffff, op_mul, sub_en ? 32'h00fffffd : 32'h00000000);
    step("mul_sub_b", 32'h00000001, 32'h41000000, op_mul, sub_en ? 32'h00000008 : 32'h00000000);
    step("mul_sub_uf", 32'h007fffff, 32'h007fffff, op_mul, 32'h00000000);
    step("mul_sub_neg", 32'h00000001, 32'h80000001, op_mul, 32'h80000000);
    step("mul_ftz_ex", 32'h00000001, 32'h3f800000, op_mul, sub_en ? 32'h00000001 : 32'h00000000);
    step("add_sub_carry", 32'h007fffff, 32'h00000001, op_add, sub_en ? 32'h00800000 : 32'h00000000);
    step("sub_to_sub", 32'h00800000, 32'h007fffff, op_sub, sub_en ? 32'h00000001 : 32'h00800000);
    step("sub_sub_zero", 32'h00000001, 32'h00000001, op_sub, 32'h00000000);
    step("zero_sign_mul", 32'h00000001, 32'h80000000, op_mul, 32'h80000000);
    step("cancel", 32'hc0490fdb, 32'h40490fdb, op_add, 32'h00000000);
    step("negz_add", 32'h80000000, 32'h80000000, op_add, 32'h80000000);
    step("negz_sub", 32'h80000000, 32'h00000000, op_sub, 32'h80000000);
    step("mul_ovf", 32'h7f7fffff, 32'h40000000, op_mul, 32'h7f800000);
    step("add_ovf", 32'h7f7fffff, 32'h7f7fffff, op_add, 32'h7f800000);
    step("inf_x_zero", 32'h7f800000, 32'h00000000, op_mul, 32'h7fc00000);
    step("inf_m_inf", 32'hff800000, 32'h7f800000, op_add, 32'h7fc00000);
    step("fin_m_ninf", 32'h41200000, 32'hff800000, op_sub, 32'h7f800000);
    step("ninf_p_fin", 32'hff800000, 32'h3f800000, op_add, 32'hff800000);
    step("ninf_x_ninf", 32'hff800000, 32'hff800000, op_mul, 32'h7f800000);
    step("inf_x_neg", 32'h7f800000, 32'hc0000000, op_mul, 32'hff800000);
    step("nan_add", 32'h7fc00000, 32'h3f800000, op_add, 32'h7fc00000);
    step("nan_sub", 32'h3f800000, 32'h7fc00000, op_sub, 32'h7fc00000);
    step("nan_mul", 32'hffc00001, 32'h00000000, op_mul, 32'h7fc00000);
    step("div_any", 32'h3f800000, 32'h40000000, op_div, 32'h7fc00000);
    step("rne_tie_even", 32'h4b800000, 32'h3f800000, op_add, 32'h4b800000);
    step("rne_tie_up", 32'h4b800001, 32'h3f800000, op_add, 32'h4b800002);
    step("neg_add", 32'hc0400000, 32'h3f800000, op_add, 32'hc0000000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_override", ieee_packet_out, 32'h0);
    if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
